// File: rtl/tmds_encoder.sv
// ---------------------------------------------------------------------------
// tmds_encoder
//
// DVI/TMDS 8b/10b channel encoder. Use one instance for each colour channel.
// The encoder has two registered stages:
//   stage 1: transition-minimised word q_m[8:0] and the popcount of q_m[7:0]
//   stage 2: DC-balancing inversion with a running disparity (bias), or a
//            control token while the display is blanked
// Latency is a fixed 2 cycles for data and control alike. The encoder
// accepts one symbol per clock and never stalls.
//
// Ports:
//   i_pix_clk  pixel clock
//   i_rst      synchronous active-high reset
//   i_data     pixel colour byte, used when i_de=1
//   i_ctrl     control bits {C1,C0}, used when i_de=0
//   i_de       display enable
//   o_tmds     10-bit encoded symbol, bit 0 is transmitted first
// ---------------------------------------------------------------------------
module tmds_encoder (
    input  logic       i_pix_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic       i_de,
    output logic [9:0] o_tmds
);

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    // ------------------------------------------------------------------
    // Stage 1: transition minimisation
    // ------------------------------------------------------------------
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] q_m_next;
    logic [3:0] n1q_next;

    always_comb begin
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, i_data[i]};
        end
    end

    // With XNOR chaining, bytes that have many ones get fewer transitions.
    // The tie at four ones is broken by bit 0 of the byte.
    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);

    always_comb begin
        q_m_next    = 9'd0;
        q_m_next[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ i_data[i])
                                   :  (q_m_next[i-1] ^ i_data[i]);
        end
        q_m_next[8] = ~use_xnor;
    end

    always_comb begin
        n1q_next = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1q_next = n1q_next + {3'b000, q_m_next[i]};
        end
    end

    logic [8:0] q_m_reg;
    logic [3:0] n1q_reg;
    logic       de_reg;
    logic [1:0] ctrl_reg;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            q_m_reg  <= 9'd0;
            n1q_reg  <= 4'd0;
            de_reg   <= 1'b0;
            ctrl_reg <= 2'b00;
        end else begin
            q_m_reg  <= q_m_next;
            n1q_reg  <= n1q_next;
            de_reg   <= i_de;
            ctrl_reg <= i_ctrl;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: DC balancing / control tokens
    // ------------------------------------------------------------------
    logic signed [4:0] bias_reg, bias_next;
    logic        [9:0] tmds_reg, tmds_next;
    logic signed [4:0] n1q_s, n0q_s, diff_s;
    logic              q8;
    logic        [7:0] q_low;

    assign q8     = q_m_reg[8];
    assign q_low  = q_m_reg[7:0];
    assign n1q_s  = $signed({1'b0, n1q_reg});
    assign n0q_s  = 5'sd8 - n1q_s;
    assign diff_s = n1q_s - n0q_s;   // ones minus zeros of q_m[7:0]

    always_comb begin
        tmds_next = tmds_reg;
        bias_next = bias_reg;
        if (!de_reg) begin
            // Clearing the bias during blanking makes every line start balanced.
            bias_next = 5'sd0;
            case (ctrl_reg)
                2'b00:   tmds_next = TOKEN_00;
                2'b01:   tmds_next = TOKEN_01;
                2'b10:   tmds_next = TOKEN_10;
                default: tmds_next = TOKEN_11;
            endcase
        end else if ((bias_reg == 5'sd0) || (n1q_reg == 4'd4)) begin
            tmds_next = {~q8, q8, (q8 ? q_low : ~q_low)};
            bias_next = bias_reg + (q8 ? diff_s : -diff_s);
        end else if (((bias_reg > 5'sd0) && (n1q_reg > 4'd4)) ||
                     ((bias_reg < 5'sd0) && (n1q_reg < 4'd4))) begin
            // Invert the payload so that it moves the bias back toward zero.
            tmds_next = {1'b1, q8, ~q_low};
            bias_next = bias_reg + (q8 ? 5'sd2 : 5'sd0) - diff_s;
        end else begin
            tmds_next = {1'b0, q8, q_low};
            bias_next = bias_reg + diff_s - (q8 ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            tmds_reg <= TOKEN_00;
            bias_reg <= 5'sd0;
        end else begin
            tmds_reg <= tmds_next;
            bias_reg <= bias_next;
        end
    end

    assign o_tmds = tmds_reg;

endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
DVI/TMDS 8b/10b channel encoder. One instance per colour channel (R, G, B), fed by the display timing generator's de/hs/vs and the pixel renderer's colour byte. Produces the 10-bit symbol for the serializer: DC-balanced video during active display, fixed control tokens during blanking. Runs entirely in the pixel clock domain.

Parameters:
(none; the algorithm is fixed by DVI 1.0 and has no configurable behaviour)

Ports:
i_pix_clk  input  1  pixel clock
i_rst  input  1  synchronous active-high reset
i_data  input  8  pixel colour byte, sampled when i_de=1
i_ctrl  input  2  control bits {C1,C0}, sampled when i_de=0 (blue channel: {vs,hs}; others: 2'b00)
i_de  input  1  display enable from the timing generator
o_tmds  output  10  encoded symbol, bit 0 transmitted first

Behaviour:
- Clock and reset: single clock i_pix_clk; reset i_rst is synchronous and active-high.
- Reset: all pipeline registers cleared (stage de=0, ctrl=00); bias=0; o_tmds=10'b1101010100 (control token 00). The first symbol after reset release is valid 2 cycles after the first sampled input.
- Latency: fixed 2 cycles from input to o_tmds for data and control alike; throughput 1 symbol/clock; no stalls.
- Stage 1 (registered):
  - n1d = popcount(i_data).
  - Use XNOR if n1d>4, or if n1d==4 and i_data[0]==0; otherwise use XOR.
  - q_m[0]=d[0]; q_m[i]=q_m[i-1] XOR/XNOR d[i] for i=1..7; q_m[8]=1 for XOR, 0 for XNOR.
  - Register q_m[8:0], n1q=popcount(q_m[7:0]) (4 bits), de, and ctrl.
- Stage 2 (registered, output): n0q=8-n1q; bias is a 5-bit signed running disparity.
  - de=0: o_tmds = token(ctrl): 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011; bias←0.
  - de=1, bias==0 or n1q==n0q: o_tmds={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; bias += q_m[8] ? (n1q-n0q) : (n0q-n1q).
  - de=1, (bias>0 and n1q>n0q) or (bias<0 and n1q<n0q): o_tmds={1, q_m[8], ~q_m[7:0]}; bias += 2*q_m[8] + (n0q-n1q).
  - Otherwise: o_tmds={0, q_m[8], q_m[7:0]}; bias += (n1q-n0q) - 2*(~q_m[8]).
- Arithmetic: all disparity math is signed and at least 5 bits wide. |bias| never exceeds 10; no saturation logic is required.
- Blanking→active transition: the first active symbol uses bias=0.
- Reset mid-line: pipeline is flushed and tokens are output immediately (the next clock).

Test Plan:
1. Reset held 3 cycles with random inputs → o_tmds=10'b1101010100 every cycle, bias=0.
2. i_de=0, i_ctrl stepped 00,01,10,11 → o_tmds 1101010100, 0010101011, 0101010100, 1010101011, each 2 cycles later.
3. Blank, then i_de=1 with i_data=0x00 twice → 10'b0100000000 (bias -8), then 10'b1111111111 (bias +2).
4. Blank, then i_data=0xFF → 10'b1000000000 (XNOR path, bias -8).
5. Random data for 10k active cycles, checked against a reference model → exact symbol match; cumulative ones-minus-zeros stays within ±10; decoding recovers i_data.
6. Full 800x525 frame driven from the timing generator → tokens on every blanking cycle, bias reset to 0 at each active-line start, 2-cycle alignment with de.
